// File: rtl/calc_result_tx_if.sv
// Byte-stream valid/ready link from the result transmitter
// to the I2C read-data shifter.
interface calc_result_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_last;

   modport master (
      output tx_data, tx_valid, tx_last,
      input  tx_ready
   );

   modport slave (
      input  tx_data, tx_valid, tx_last,
      output tx_ready
   );
endinterface

// File: rtl/calc_result_tx.sv
// Streams the significant bytes of a captured calculator result.
// Define CALC_RESULT_TX_CRC_EN to append a CRC-8 (poly 0x07) byte.
module calc_result_tx #(
   parameter bit MSB_FIRST = 1'b1,
   parameter bit FIXED_LEN = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            operation,
   input  logic [63:0]           result,
   input  logic                  abort,
   calc_result_tx_if.master      tx,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t      state;
   logic [63:0] shadow;
   logic [1:0]  op_q;
   logic [3:0]  cnt;
   logic [3:0]  nxt;
   logic [3:0]  n_q;
   logic [3:0]  last_idx;

   function automatic logic [3:0] frame_len(input logic [1:0] op);
      logic [3:0] n;
      n = 4'd5;
      if (FIXED_LEN) n = 4'd8;
      else if (op == 2'b10) n = 4'd8;
      else if (op == 2'b11) n = 4'd4;
      return n;
   endfunction

   function automatic logic [7:0] pick(
      input logic [63:0] r,
      input logic [3:0]  n,
      input logic [3:0]  k
   );
      logic [3:0]  idx;
      logic [63:0] s;
      idx = MSB_FIRST ? (n - 4'd1 - k) : k;
      s   = r >> {idx[2:0], 3'b000};
      return s[7:0];
   endfunction

   assign nxt = cnt + 4'd1;
   assign n_q = frame_len(op_q);

`ifdef CALC_RESULT_TX_CRC_EN
   logic [7:0] crc;
   logic [7:0] crc_next;

   function automatic logic [7:0] crc8_step(
      input logic [7:0] c,
      input logic [7:0] d
   );
      logic [7:0] x;
      x = c ^ d;
      for (int i = 0; i < 8; i++)
         x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
      return x;
   endfunction

   assign crc_next = crc8_step(crc, tx.tx_data);
   assign last_idx = n_q;
`else
   assign last_idx = n_q - 4'd1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shadow      <= '0;
         op_q        <= '0;
         cnt         <= '0;
         tx.tx_data  <= '0;
         tx.tx_valid <= 1'b0;
         tx.tx_last  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef CALC_RESULT_TX_CRC_EN
         crc         <= '0;
`endif
      end else if (abort) begin
         // abort beats start and the final handshake alike
         state       <= IDLE;
         tx.tx_valid <= 1'b0;
         tx.tx_last  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef CALC_RESULT_TX_CRC_EN
         crc         <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shadow      <= result;
                  op_q        <= operation;
                  cnt         <= '0;
                  tx.tx_data  <= pick(result, frame_len(operation), 4'd0);
                  tx.tx_valid <= 1'b1;
                  tx.tx_last  <= 1'b0;
                  busy        <= 1'b1;
                  state       <= SEND;
`ifdef CALC_RESULT_TX_CRC_EN
                  crc         <= '0;
`endif
               end
            end
            SEND: begin
               if (tx.tx_ready) begin
                  if (cnt == last_idx) begin
                     tx.tx_valid <= 1'b0;
                     tx.tx_last  <= 1'b0;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     cnt <= nxt;
`ifdef CALC_RESULT_TX_CRC_EN
                     crc <= crc_next;
                     if (nxt == n_q) begin
                        tx.tx_data <= crc_next;
                        tx.tx_last <= 1'b1;
                     end else begin
                        tx.tx_data <= pick(shadow, n_q, nxt);
                        tx.tx_last <= 1'b0;
                     end
`else
                     tx.tx_data <= pick(shadow, n_q, nxt);
                     tx.tx_last <= (nxt == last_idx);
`endif
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_result_tx.sv
// Directed bench for calc_result_tx: MSB-first instance (a)
// and LSB-first instance (b) share stimulus.
module tb_calc_result_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        ready = 1'b0;
   logic [1:0]  operation = 2'b00;
   logic [63:0] result = '0;
   logic        busy_a, done_a, busy_b, done_b;

   calc_result_tx_if if_a ();
   calc_result_tx_if if_b ();

   assign if_a.tx_ready = ready;
   assign if_b.tx_ready = ready;

   calc_result_tx #(.MSB_FIRST(1'b1), .FIXED_LEN(1'b0)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .operation (operation),
      .result    (result),
      .abort     (abort),
      .tx        (if_a),
      .busy      (busy_a),
      .done      (done_a)
   );

   calc_result_tx #(.MSB_FIRST(1'b0), .FIXED_LEN(1'b0)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .operation (operation),
      .result    (result),
      .abort     (abort),
      .tx        (if_b),
      .busy      (busy_b),
      .done      (done_b)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   logic [7:0] exp_b [0:8];
   int exp_n;

   function automatic logic [7:0] d_of(input bit s);
      return s ? if_b.tx_data : if_a.tx_data;
   endfunction
   function automatic logic v_of(input bit s);
      return s ? if_b.tx_valid : if_a.tx_valid;
   endfunction
   function automatic logic l_of(input bit s);
      return s ? if_b.tx_last : if_a.tx_last;
   endfunction
   function automatic logic b_of(input bit s);
      return s ? busy_b : busy_a;
   endfunction
   function automatic logic dn_of(input bit s);
      return s ? done_b : done_a;
   endfunction

   function automatic logic [7:0] ref_crc(input int n);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         c = c ^ exp_b[i];
         for (int j = 0; j < 8; j++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [1:0] op,
                           input logic [63:0] res);
      @(negedge clk);
      operation = op;
      result    = res;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1-0-0-1
   task automatic run_frame(input bit sel, input int mode,
                            input bit inject);
      int n;
      int k;
      int cyc;
      n = exp_n;
      k = 0;
      cyc = 0;
`ifdef CALC_RESULT_TX_CRC_EN
      exp_b[n] = ref_crc(n);
      n++;
`endif
      while (k < n && cyc < 200) begin
         ready = (mode == 0) ? 1'b1
               : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (inject) begin
            start = (cyc == 2);
            if (cyc == 2) begin
               operation = 2'b10;
               result    = 64'h5555_AAAA_5555_AAAA;
            end
         end
         check("tx_valid", 64'(v_of(sel)), 64'(1));
         check("tx_data", 64'(d_of(sel)), 64'(exp_b[k]));
         check("tx_last", 64'(l_of(sel)), 64'(k == n - 1));
         check("busy", 64'(b_of(sel)), 64'(1));
         if (ready) k++;
         cyc++;
         @(negedge clk);
      end
      ready = 1'b0;
      start = 1'b0;
      check("bytes_sent", 64'(k), 64'(n));
      check("done_pulse", 64'(dn_of(sel)), 64'(1));
      check("busy_done", 64'(b_of(sel)), 64'(0));
      check("valid_done", 64'(v_of(sel)), 64'(0));
      @(negedge clk);
      check("done_clear", 64'(dn_of(sel)), 64'(0));
      check("valid_idle", 64'(v_of(sel)), 64'(0));
   endtask

   initial begin
      #12;
      check("rst_data", 64'(if_a.tx_data), 64'(0));
      check("rst_valid", 64'(if_a.tx_valid), 64'(0));
      check("rst_last", 64'(if_a.tx_last), 64'(0));
      check("rst_busy", 64'(busy_a), 64'(0));
      check("rst_done", 64'(done_a), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // ADD, back-to-back
      exp_b[0] = 8'h01; exp_b[1] = 8'h23; exp_b[2] = 8'h45;
      exp_b[3] = 8'h67; exp_b[4] = 8'h89; exp_n = 5;
      do_start(2'b00, 64'h0000_0001_2345_6789);
      run_frame(1'b0, 0, 1'b0);

      // MUL with stalls
      exp_b[0] = 8'hFE; exp_b[1] = 8'hDC; exp_b[2] = 8'hBA;
      exp_b[3] = 8'h98; exp_b[4] = 8'h76; exp_b[5] = 8'h54;
      exp_b[6] = 8'h32; exp_b[7] = 8'h10; exp_n = 8;
      do_start(2'b10, 64'hFEDC_BA98_7654_3210);
      run_frame(1'b0, 1, 1'b0);

      // DIV, LSB-first instance
      exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD;
      exp_b[3] = 8'hDE; exp_n = 4;
      do_start(2'b11, 64'h0000_0000_DEAD_BEEF);
      run_frame(1'b1, 0, 1'b0);

      // start while busy is ignored
      exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'h56;
      exp_b[3] = 8'h78; exp_b[4] = 8'h9A; exp_n = 5;
      do_start(2'b00, 64'hFFFF_FF12_3456_789A);
      run_frame(1'b0, 0, 1'b1);

      // abort after the second handshake of a MUL frame
      do_start(2'b10, 64'hFEDC_BA98_7654_3210);
      ready = 1'b1;
      check("ab_byte0", 64'(if_a.tx_data), 64'hFE);
      @(negedge clk);
      check("ab_byte1", 64'(if_a.tx_data), 64'hDC);
      @(negedge clk);
      check("ab_byte2", 64'(if_a.tx_data), 64'hBA);
      abort = 1'b1;
      ready = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      check("ab_valid", 64'(if_a.tx_valid), 64'(0));
      check("ab_last", 64'(if_a.tx_last), 64'(0));
      check("ab_busy", 64'(busy_a), 64'(0));
      check("ab_done", 64'(done_a), 64'(0));
      @(negedge clk);
      check("ab_done2", 64'(done_a), 64'(0));

      exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE;
      exp_b[3] = 8'hEF; exp_n = 4;
      do_start(2'b11, 64'h0000_0000_DEAD_BEEF);
      run_frame(1'b0, 0, 1'b0);

      // abort and start together: nothing captured
      @(negedge clk);
      operation = 2'b00;
      result    = 64'h1;
      start     = 1'b1;
      abort     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("as_valid", 64'(if_a.tx_valid), 64'(0));
      check("as_busy", 64'(busy_a), 64'(0));
      @(negedge clk);
      check("as_done", 64'(done_a), 64'(0));

      // DIV of 1 (CRC byte 07 when enabled)
      exp_b[0] = 8'h00; exp_b[1] = 8'h00; exp_b[2] = 8'h00;
      exp_b[3] = 8'h01; exp_n = 4;
      do_start(2'b11, 64'h1);
      run_frame(1'b0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule

// File: doc/calc_result_tx.md
Name: calc_result_tx

Overview:
Transmit-side companion to the combinational calculator. On a start pulse it captures the calculator's 64-bit result and 2-bit operation code, then streams only the significant result bytes over a valid/ready byte interface to the I2C target's read-data shifter. It sits between the calculator output and the I2C read path and asserts done once the last byte has been accepted.

Parameters:
MSB_FIRST, 1, 1 = most-significant sent byte first (I2C order); 0 = least-significant first.
FIXED_LEN, 0, 1 = always send 8 bytes regardless of operation; 0 = length per operation (see Behaviour).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to capture result and begin transmission
operation  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; sampled with start
result  input  64  calculator result; sampled with start
abort  input  1  I2C STOP/NACK seen; cancels transfer
tx_data  output  8  current byte
tx_valid  output  1  tx_data is valid
tx_ready  input  1  consumer accepts byte when tx_valid & tx_ready
tx_last  output  1  high with the final byte of the frame
busy  output  1  high from the cycle after accepted start until return to IDLE
done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; tx_data=0x00, tx_valid=0, tx_last=0, busy=0, done=0; shadow registers and byte counter cleared.
- Byte count N: ADD/SUB 5 bytes (result[39:0], covers the 33-bit result); MUL 8 bytes (result[63:0]); DIV 4 bytes (result[31:0]). With FIXED_LEN=1, N=8 for all operations.
- MSB_FIRST=1: byte k (k=0..N-1) = result[8*(N-1-k)+:8]. MSB_FIRST=0: byte k = result[8*k+:8].
- States: IDLE -> SEND -> DONE -> IDLE.
- IDLE: start=1 -> latch result/operation into shadow registers, load byte 0, counter=0, go to SEND. Next cycle tx_valid=1, busy=1 (one-cycle latency from start to first valid).
- SEND: tx_data, tx_valid, and tx_last are held stable until the handshake completes. On tx_valid&tx_ready: if the counter is N-1 -> tx_valid=0, go to DONE; else counter+1 and present the next byte in the next cycle. This allows back-to-back transfers: one byte per cycle while tx_ready stays high. tx_last=1 only while the final byte is presented.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. A start in the DONE cycle is ignored.
- start while busy (SEND/DONE) is ignored. Changes on result/operation after capture do not affect the frame.
- abort has the highest priority in any state: the next cycle is IDLE, tx_valid=0, tx_last=0, busy=0, and no done pulse. If abort and start are high in the same cycle, abort wins and nothing is captured. If abort coincides with the final handshake, the byte counts as sent but done is suppressed.
- tx_ready while tx_valid=0 has no effect.

Optional Feature:
CALC_RESULT_TX_CRC_EN: when defined, a CRC-8 byte is appended after the N data bytes.
- CRC-8 uses polynomial 0x07, init 0x00, no reflection and no final XOR, computed over the data bytes in the order sent.
- tx_last moves from the last data byte to the CRC byte; the frame length is N+1, and done follows CRC acceptance.
- The CRC register is reset by start and by abort.
When the macro is not defined, no CRC logic is present and the frame is exactly N bytes.

Test Plan:
- ADD, result=0x0000_0001_2345_6789, tx_ready=1 -> bytes 01,23,45,67,89 on consecutive cycles; tx_last on 89; done one cycle after the 89 handshake.
- MUL, result=0xFEDC_BA98_7654_3210, tx_ready toggling 1-0-0-1 -> 8 bytes FE..10 in order; tx_data held stable during every stall; no byte duplicated or dropped.
- DIV, result=0x0000_0000_DEAD_BEEF, MSB_FIRST=0 -> EF,BE,AD,DE; tx_last on DE.
- During an ADD frame, pulse start with MUL and change result -> ignored; the original 5-byte frame completes unchanged.
- Abort right after the 2nd byte handshake of a MUL frame -> tx_valid=0 and busy=0 next cycle, no done; a following DIV start sends a correct 4-byte frame.
- CALC_RESULT_TX_CRC_EN defined, DIV, result=0x1 -> 00,00,00,01 then CRC 07 with tx_last; done follows.
